// File: rtl/requant_rshift_pkg.sv
// Shared widths for the requantizing right-shift pipeline.
package requant_rshift_pkg;

    localparam int DEF_IN_W  = 6;  // default input sample width
    localparam int DEF_OUT_W = 4;  // default output sample width
    localparam int DEF_CNT_W = 8;  // default saturation counter width
    localparam int SHIFT_W   = 3;  // shift amount field, 0..7

endpackage

// File: rtl/requant_rshift_sat_clip.sv
// Combinational signed clip from a wide value down to OUT_W bits,
// flagging when the value had to be clipped.
module sat_clip #(
    parameter int DIN_W = 8,
    parameter int OUT_W = 4
) (
    input  logic signed [DIN_W-1:0] din,
    output logic        [OUT_W-1:0] dout,
    output logic                    sat
);

    // Largest and smallest values representable in OUT_W signed bits,
    // sign-extended to DIN_W so the comparisons stay in one width.
    localparam logic signed [DIN_W-1:0] MAX_V = {{(DIN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [DIN_W-1:0] MIN_V = {{(DIN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clip to the representable range, otherwise pass the low bits through.
    always_comb begin
        dout = din[OUT_W-1:0];
        sat  = 1'b0;
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/requant_rshift.sv
// Requantizer: rounding arithmetic right shift followed by a saturating
// clip to OUT_W bits, as a two-stage stallable pipeline, plus a saturating
// count of clipped beats delivered downstream.
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both 1. The producer holds valid and data stable until that
// edge; the consumer's ready may change freely. Both pipeline stages move
// together only when the output stage is empty or being drained
// (en = !m_valid || m_ready), and s_ready is exactly en.
module requant_rshift
    import requant_rshift_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [IN_W-1:0]    s_data,
    input  logic [SHIFT_W-1:0] s_shift,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_data,
    output logic               m_sat,
    input  logic               sat_clr,
    output logic [CNT_W-1:0]   sat_cnt
);

    localparam int                  XW  = IN_W + 2;
    localparam logic signed [XW-1:0] ONE = XW'(1);

    logic                  en;
    logic signed [XW-1:0]  x_ext;
    logic signed [XW-1:0]  rnd;
    logic signed [XW-1:0]  r_next;
    logic                  s1_valid;
    logic signed [XW-1:0]  s1_r;
    logic [OUT_W-1:0]      clip_data;
    logic                  clip_sat;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    // Round-half-up right shift in IN_W+2 bits. Shifts larger than IN_W
    // always land on zero (the rounding term dominates any input), so they
    // are short-circuited, which also keeps the rounding term in range.
    always_comb begin
        x_ext  = {{2{s_data[IN_W-1]}}, s_data};
        rnd    = '0;
        r_next = x_ext;
        if (s_shift != '0) begin
            if (int'(s_shift) > IN_W) begin
                r_next = '0;
            end else begin
                rnd    = ONE << (s_shift - SHIFT_W'(1));
                r_next = (x_ext + rnd) >>> s_shift;
            end
        end
    end

    sat_clip #(
        .DIN_W (XW),
        .OUT_W (OUT_W)
    ) u_clip (
        .din  (s1_r),
        .dout (clip_data),
        .sat  (clip_sat)
    );

    // Stage 1: capture the shifted value when the pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else if (en) begin
            s1_valid <= s_valid;
            s1_r     <= r_next;
        end
    end

    // Stage 2: capture the clipped value; held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
        end else if (en) begin
            m_valid <= s1_valid;
            m_data  <= clip_data;
            m_sat   <= clip_sat;
        end
    end

    // Count clipped beats accepted downstream; stick at all-ones, clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (m_valid && m_ready && m_sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_requant_rshift.sv
// Self-checking bench for requant_rshift with a behavioural model.
module tb_requant_rshift;

    localparam int IN_W    = 6;
    localparam int OUT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int OMAX    = (1 << (OUT_W - 1)) - 1;
    localparam int OMIN    = -(1 << (OUT_W - 1));
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic [2:0]       s_shift;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_sat;
    logic             sat_clr;
    logic [CNT_W-1:0] sat_cnt;

    logic [OUT_W:0] exp_q[$];   // {sat, data} per expected output beat
    int             exp_cnt;
    int             n_checks;
    int             n_fail;

    requant_rshift #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_shift (s_shift),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sat   (m_sat),
        .sat_clr (sat_clr),
        .sat_cnt (sat_cnt)
    );

    // Clock and initial reset level
    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_shift = '0;
        m_ready = 1'b1;
        sat_clr = 1'b0;
    end
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Reference: floor((x + 2^(sh-1)) / 2^sh) for sh > 0, x for sh = 0, then clip.
    function automatic logic [OUT_W:0] model(input int x, input int sh);
        int r, num, den;
        if (sh == 0) begin
            r = x;
        end else begin
            num = x + (1 << (sh - 1));
            den = 1 << sh;
            r   = num / den;
            if ((num % den) != 0 && num < 0) r = r - 1;
        end
        if (r > OMAX) return {1'b1, OUT_W'(OMAX)};
        if (r < OMIN) return {1'b1, OUT_W'(OMIN)};
        return {1'b0, OUT_W'(r)};
    endfunction

    // Driver: apply one cycle of inputs on the falling edge.
    task automatic drive(input logic v, input int d, input int sh, input logic mr, input logic clr);
        @(negedge clk);
        s_valid = v;
        s_data  = IN_W'(d);
        s_shift = 3'(sh);
        m_ready = mr;
        sat_clr = clr;
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        n_checks++; if (m_sat !== 1'b0) begin n_fail++; $display("FAIL reset_m_sat: got %b want 0", m_sat); end
        n_checks++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready: got %b want 1", s_ready); end
        exp_cnt = 0;
    endtask

    // Single beats with known results and exact 2-cycle latency.
    task automatic test_directed;
        int dt[5], st[5], ed[5], es[5], ec[5];
        dt = '{13, -6, -32, 31, 31};
        st = '{2, 2, 2, 2, 0};
        ed = '{3, -1, -8, 7, 7};
        es = '{0, 0, 0, 1, 1};
        ec = '{0, 0, 0, 1, 2};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, dt[i], st[i], 1'b1, 1'b0);
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %b want 0", i, m_valid); end
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency: m_valid got %b want 1", i, m_valid); end
            n_checks++; if (m_data !== OUT_W'(ed[i])) begin n_fail++; $display("FAIL dir%0d_data: got %0d want %0d", i, $signed(m_data), ed[i]); end
            n_checks++; if (m_sat !== es[i][0]) begin n_fail++; $display("FAIL dir%0d_sat: got %b want %0d", i, m_sat, es[i]); end
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            n_checks++; if (sat_cnt !== CNT_W'(ec[i])) begin n_fail++; $display("FAIL dir%0d_sat_cnt: got %0d want %0d", i, sat_cnt, ec[i]); end
        end
        exp_cnt = 2;
    endtask

    // v <<< 2 with shift 2 returns v; m_ready toggles every cycle.
    task automatic test_round_trip_stall;
        int pend[$];
        int n_out;
        logic [OUT_W-1:0] ev;
        exp_q.delete();
        for (int v = -8; v <= 7; v++) pend.push_back(v);
        n_out = 0;
        for (int cyc = 0; cyc < 200 && n_out < 16; cyc++) begin
            drive(pend.size() != 0, (pend.size() != 0) ? pend[0] * 4 : 0, 2, (cyc % 2) == 0, 1'b0);
            if (m_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rt_unexpected: got output %0d want none", $signed(m_data));
                end else if ({m_sat, m_data} !== exp_q[0]) begin
                    n_fail++; $display("FAIL rt_data: got sat=%b data=%0d want sat=%b data=%0d",
                                       m_sat, $signed(m_data), exp_q[0][OUT_W], $signed(exp_q[0][OUT_W-1:0]));
                end
                if (m_ready) begin
                    n_out++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                ev = OUT_W'(pend.pop_front());
                exp_q.push_back({1'b0, ev});
            end
        end
        n_checks++;
        if (n_out != 16 || exp_q.size() != 0 || pend.size() != 0) begin
            n_fail++; $display("FAIL rt_count: got %0d outputs (%0d pending, %0d expected left) want 16", n_out, pend.size(), exp_q.size());
        end
    endtask

    // Random data, shifts, back-pressure and clears against the model.
    task automatic test_random;
        logic have, mr, clr, out_hs, out_sat;
        int cx, csh;
        exp_q.delete();
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        exp_cnt = 0;
        have = 1'b0; cx = 0; csh = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!have && cyc < 400 && $urandom_range(0, 3) != 0) begin
                have = 1'b1;
                cx   = int'($urandom_range(0, 63)) - 32;
                csh  = int'($urandom_range(0, 7));
            end
            if (cyc >= 400 && !have && exp_q.size() == 0) break;
            mr  = (cyc < 400) ? ($urandom_range(0, 2) != 0) : 1'b1;
            clr = (cyc < 400) && ($urandom_range(0, 39) == 0);
            drive(have, cx, csh, mr, clr);
            n_checks++;
            if (sat_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL rnd_sat_cnt: got %0d want %0d", sat_cnt, exp_cnt); end
            out_hs = m_valid && m_ready;
            out_sat = 1'b0;
            if (m_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_unexpected: got output %0d want none", $signed(m_data));
                end else begin
                    if ({m_sat, m_data} !== exp_q[0]) begin
                        n_fail++; $display("FAIL rnd_data: got sat=%b data=%0d want sat=%b data=%0d",
                                           m_sat, $signed(m_data), exp_q[0][OUT_W], $signed(exp_q[0][OUT_W-1:0]));
                    end
                    if (m_ready) begin
                        out_sat = exp_q[0][OUT_W];
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (have && s_ready) begin
                exp_q.push_back(model(cx, csh));
                have = 1'b0;
            end
            if (clr) exp_cnt = 0;
            else if (out_hs && out_sat && exp_cnt < CNT_MAX) exp_cnt++;
        end
        n_checks++;
        if (exp_q.size() != 0 || have) begin n_fail++; $display("FAIL rnd_drain: got %0d beats outstanding want 0", exp_q.size()); end
    endtask

    // 300 clipped beats; counter sticks at 255; clear on the 300th handshake.
    task automatic test_sat_count;
        int n_in, n_out;
        logic hs;
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        exp_cnt = 0;
        n_in = 0; n_out = 0;
        for (int cyc = 0; cyc < 400 && n_out < 300; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (sat_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL cnt_track: got %0d want %0d", sat_cnt, exp_cnt); end
            hs      = m_valid;
            s_valid = (n_in < 300);
            s_data  = IN_W'(31);
            s_shift = 3'd0;
            m_ready = 1'b1;
            sat_clr = hs && (n_out == 299);
            #1;
            if (sat_clr) begin
                n_checks++;
                if (sat_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_ceiling: got %0d want 255", sat_cnt); end
            end
            if (s_valid && s_ready) n_in++;
            if (hs) n_out++;
            if (sat_clr) exp_cnt = 0;
            else if (hs && exp_cnt < CNT_MAX) exp_cnt++;
        end
        n_checks++;
        if (n_out != 300) begin n_fail++; $display("FAIL cnt_timeout: got %0d handshakes want 300", n_out); end
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        n_checks++;
        if (sat_cnt !== '0) begin n_fail++; $display("FAIL cnt_clear: got %0d want 0", sat_cnt); end
        exp_cnt = 0;
    endtask

    // Reset with two beats in flight; only post-reset data may come out.
    task automatic test_reset_midstream;
        logic seen;
        drive(1'b1, 31, 0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 0, 0, 1'b1, 1'b0);
        n_checks++;
        if (sat_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d want 1", sat_cnt); end
        drive(1'b1, 31, 0, 1'b1, 1'b0);
        drive(1'b1, 13, 2, 1'b1, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
        n_checks++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL mid_sat_cnt: got %0d want 0", sat_cnt); end
        n_checks++; if (m_data !== '0 || m_sat !== 1'b0) begin n_fail++; $display("FAIL mid_m_data: got sat=%b data=%0d want 0/0", m_sat, $signed(m_data)); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_s_ready: got %b want 1", s_ready); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, -6, 2, 1'b1, 1'b0);
        seen = 1'b0;
        for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            if (m_valid) begin
                seen = 1'b1;
                n_checks++;
                if (m_data !== 4'hF || m_sat !== 1'b0) begin
                    n_fail++; $display("FAIL mid_first_out: got sat=%b data=%0d want sat=0 data=-1", m_sat, $signed(m_data));
                end
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL mid_timeout: got no output want one beat"); end
    endtask

    // Test sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        test_reset();
        test_directed();
        test_round_trip_stall();
        test_random();
        test_sat_count();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/requant_rshift.md
REQUANT_RSHIFT -- requirements
Module: requant_rshift

Interface
REQ-001 Parameter IN_W, default 6, input sample width (signed two's complement).
REQ-002 Parameter OUT_W, default 4, output sample width (signed two's complement); OUT_W <= IN_W.
REQ-003 Parameter CNT_W, default 8, saturation-counter width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_valid  input  1  input beat valid.
REQ-007 s_ready  output  1  block can accept input beat.
REQ-008 s_data  input  IN_W  signed sample, pre-scaled by left shift upstream.
REQ-009 s_shift  input  3  right-shift amount for this beat, 0..7.
REQ-010 m_valid  output  1  output beat valid.
REQ-011 m_ready  input  1  downstream accepts output beat.
REQ-012 m_data  output  OUT_W  signed requantized sample.
REQ-013 m_sat  output  1  this output beat was clipped.
REQ-014 sat_clr  input  1  synchronous clear of sat_cnt.
REQ-015 sat_cnt  output  CNT_W  count of clipped output beats accepted downstream.

Function
REQ-016 Input handshake on s_valid && s_ready; output handshake on m_valid && m_ready; s_data and s_shift are sampled together at the input handshake.
REQ-017 Two-stage pipeline: stage 1 registers the rounded shift result, stage 2 registers the saturated result and m_sat; latency is 2 cycles from input handshake to m_valid.
REQ-018 Global stall: en = !m_valid || m_ready; s_ready = en; both stages advance only when en = 1.
REQ-019 Throughput is 1 beat/cycle while m_ready is held high.
REQ-020 Stage 1 for shift sh > 0: r = (x + 2^(sh-1)) >>> sh, computed sign-extended in IN_W+2 bits with no intermediate overflow.
REQ-021 Stage 1 for sh = 0: r = x, with no rounding term.
REQ-022 sh >= IN_W is legal and gives 0 for non-negative x; negative x follows REQ-020 exactly (e.g. -32, sh=7 -> 0).
REQ-023 Stage 2: if r > 2^(OUT_W-1)-1, m_data = 2^(OUT_W-1)-1 and m_sat = 1.
REQ-024 Stage 2: if r < -2^(OUT_W-1), m_data = -2^(OUT_W-1) and m_sat = 1.
REQ-025 Stage 2: otherwise m_data = r[OUT_W-1:0] and m_sat = 0.
REQ-026 m_data and m_sat hold stable while m_valid = 1 and m_ready = 0.
REQ-027 Bubbles (s_valid = 0 while en = 1) propagate as invalid stages; data in invalid stages is don't-care.
REQ-028 sat_cnt increments by 1 on each output handshake with m_sat = 1.
REQ-029 sat_cnt saturates at 2^CNT_W-1 and does not wrap.
REQ-030 sat_clr forces sat_cnt to 0 on the next edge; when it coincides with an increment, clear wins (result 0).
REQ-031 Round-trip property: for any OUT_W-bit v, input v <<< (IN_W-OUT_W) with sh = IN_W-OUT_W yields m_data = v, m_sat = 0.

Reset
REQ-032 While rst is high: both stage valids are 0, m_valid = 0, m_data = 0, m_sat = 0, sat_cnt = 0.
REQ-033 s_ready = 1 during and immediately after reset (m_valid = 0).
REQ-034 Reset mid-stream discards all in-flight beats; no beat accepted before reset appears at the output after it.

Structure
REQ-035 A shared package holds the default widths IN_W/OUT_W/CNT_W and the shift-field width (3).
REQ-036 The saturating clip is a natural sub-module, sat_clip (combinational, parameters IN_W+2 -> OUT_W, outputs value and flag); the pipeline and counter stay in requant_rshift.

Verification (IN_W=6, OUT_W=4, m_ready=1 unless stated)
REQ-037 s_data=13, sh=2 -> m_data=3, m_sat=0, exactly 2 cycles after handshake.
REQ-038 s_data=-6, sh=2 -> m_data=-1, m_sat=0; s_data=-32, sh=2 -> m_data=-8, m_sat=0.
REQ-039 s_data=31, sh=2 -> m_data=7, m_sat=1, sat_cnt=1; s_data=31, sh=0 -> m_data=7, m_sat=1, sat_cnt=2.
REQ-040 Stream v=-8..7 as v<<<2 with sh=2, m_ready toggling 1/0 each cycle -> outputs -8..7 in order, none lost or duplicated, held while stalled.
REQ-041 Drive 300 saturating beats with sat_clr asserted on the 300th handshake cycle -> sat_cnt holds at 255, then reads 0.
REQ-042 Assert rst with 2 beats in flight -> m_valid=0 and sat_cnt=0 immediately; after release the first output is the first post-reset input.
